multi_digit_display: RTL and testbench

MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

---
 rtl/display_pkg.sv | 46 ++++
 rtl/hex_segment_encoder.sv | 12 +
 rtl/multi_digit_display.sv | 154 +++++++++++++++
 tb/tb_multi_digit_display.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed hex display:
// segment font, segment bit positions and idle levels.
package display_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Active-high font, bit 6 = a ... bit 0 = g
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,
    7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F,
    7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  localparam logic [SEG_W-1:0] SEG_DARK_HIGH = 7'h00;
  localparam logic [SEG_W-1:0] SEG_DARK_LOW  = 7'h7F;
  localparam logic             DP_DARK_HIGH  = 1'b0;
  localparam logic             DP_DARK_LOW   = 1'b1;

  function automatic logic [SEG_W-1:0] hex_to_seg(
    input logic [3:0] nib
  );
    return SEG_TABLE[nib];
  endfunction

  function automatic logic [SEG_W-1:0] seg_inactive(
    input int active_low
  );
    return (active_low != 0) ? SEG_DARK_LOW : SEG_DARK_HIGH;
  endfunction

  function automatic logic dp_inactive(
    input int active_low
  );
    return (active_low != 0) ? DP_DARK_LOW : DP_DARK_HIGH;
  endfunction

endpackage

// File: rtl/hex_segment_encoder.sv
// Combinational nibble to active-high
// seven-segment pattern lookup.
module hex_segment_encoder
  import display_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] segments
);

  assign segments = hex_to_seg(nibble);

endmodule

// File: rtl/multi_digit_display.sv
// Multiplexed hex display driver with shadow/display
// double buffering swapped only on frame boundaries.
module multi_digit_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS          = 4,
  parameter int SCAN_DIVIDER        = 50000,
  parameter int ACTIVE_LOW_SEGMENTS = 0,
  parameter int ACTIVE_LOW_DIGITS   = 0,
  parameter int BLANK_LEADING_ZEROS = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    value_valid,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    value_ready,
  output logic [SEG_W-1:0]        segments,
  output logic                    decimal_point,
  output logic [NUM_DIGITS-1:0]   digit_select
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIVIDER);

  localparam logic [PW-1:0] PMAX =
    PW'(SCAN_DIVIDER - 1);
  localparam logic [IW-1:0] IMAX =
    IW'(NUM_DIGITS - 1);

  localparam logic [SEG_W-1:0] SEG_OFF =
    seg_inactive(ACTIVE_LOW_SEGMENTS);
  localparam logic DP_OFF =
    dp_inactive(ACTIVE_LOW_SEGMENTS);
  localparam logic [NUM_DIGITS-1:0] DSEL_OFF =
    (ACTIVE_LOW_DIGITS != 0) ? '1 : '0;

  logic [PW-1:0]         presc_q;
  logic [IW-1:0]         idx_q;
  logic                  pending_q;
  logic [VW-1:0]         shadow_q;
  logic [NUM_DIGITS-1:0] shadow_dp_q;
  logic [VW-1:0]         disp_q;
  logic [NUM_DIGITS-1:0] disp_dp_q;

  logic tick;
  logic frame;
  logic capture;

  assign tick    = enable && (presc_q == PMAX);
  assign frame   = tick && (idx_q == IMAX);
  assign capture = value_valid && !pending_q;

  assign value_ready = !pending_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (!enable) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IMAX) ? '0 : idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // capture implies !pending, so a swap and a capture
  // on one edge never touch the same shadow contents
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= 1'b0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
    end else begin
      if (frame && pending_q) begin
        disp_q    <= shadow_q;
        disp_dp_q <= shadow_dp_q;
      end
      if (capture) begin
        shadow_q    <= value;
        shadow_dp_q <= dp_mask;
      end
      pending_q <= capture || (pending_q && !frame);
    end
  end

  logic [3:0]            sel_nib;
  logic [SEG_W-1:0]      enc_seg;
  logic [NUM_DIGITS-1:0] zero_above;
  logic                  blank;
  logic [NUM_DIGITS-1:0] onehot;

  assign sel_nib = disp_q[{idx_q, 2'b00} +: 4];

  hex_segment_encoder u_enc (
    .nibble   (sel_nib),
    .segments (enc_seg)
  );

  // zero_above[i]: digit i and everything left of it is 0
  always_comb begin
    zero_above = '0;
    zero_above[NUM_DIGITS-1] =
      (disp_q[VW-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] &&
        (disp_q[4*i +: 4] == 4'h0);
    end
  end

  assign blank = (BLANK_LEADING_ZEROS != 0) &&
    (idx_q != '0) && zero_above[idx_q];

  always_comb begin
    onehot        = '0;
    onehot[idx_q] = 1'b1;
  end

  logic [SEG_W-1:0]      seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] dsel_d;

  always_comb begin
    seg_d  = SEG_OFF;
    dp_d   = DP_OFF;
    dsel_d = DSEL_OFF;
    if (enable) begin
      seg_d  = (blank ? '0 : enc_seg) ^ SEG_OFF;
      dp_d   = disp_dp_q[idx_q] ^ DP_OFF;
      dsel_d = onehot ^ DSEL_OFF;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      segments      <= SEG_OFF;
      decimal_point <= DP_OFF;
      digit_select  <= DSEL_OFF;
    end else begin
      segments      <= seg_d;
      decimal_point <= dp_d;
      digit_select  <= dsel_d;
    end
  end

endmodule

// File: tb/tb_multi_digit_display.sv
// Scoreboard bench: active-high and active-low copies
// checked against a slot/frame-level reference model.
module tb_multi_digit_display;

  localparam int N  = 4;
  localparam int SD = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        value_valid = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;

  logic       ready_h, ready_l;
  logic [6:0] seg_h, seg_l;
  logic       dp_h, dp_l;
  logic [3:0] ds_h, ds_l;

  always #5 clock = ~clock;

  multi_digit_display #(
    .NUM_DIGITS(N), .SCAN_DIVIDER(SD),
    .ACTIVE_LOW_SEGMENTS(0), .ACTIVE_LOW_DIGITS(0),
    .BLANK_LEADING_ZEROS(1)
  ) dut_h (
    .clock(clock), .reset_n(reset_n),
    .enable(enable), .value_valid(value_valid),
    .value(value), .dp_mask(dp_mask),
    .value_ready(ready_h), .segments(seg_h),
    .decimal_point(dp_h), .digit_select(ds_h)
  );

  multi_digit_display #(
    .NUM_DIGITS(N), .SCAN_DIVIDER(SD),
    .ACTIVE_LOW_SEGMENTS(1), .ACTIVE_LOW_DIGITS(1),
    .BLANK_LEADING_ZEROS(1)
  ) dut_l (
    .clock(clock), .reset_n(reset_n),
    .enable(enable), .value_valid(value_valid),
    .value(value), .dp_mask(dp_mask),
    .value_ready(ready_l), .segments(seg_l),
    .decimal_point(dp_l), .digit_select(ds_l)
  );

  typedef struct {
    int unsigned cyc;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dsel;
    logic        ready;
  } exp_t;

  exp_t q[$];

  int unsigned edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int failures = 0;

  logic [6:0] font [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Reference model: slot position, digit, buffers
  int          m_presc;
  int          m_idx;
  bit          m_pend;
  int unsigned m_shadow, m_disp;
  bit [3:0]    m_sdp, m_ddp;

  function automatic void model_clear();
    m_presc = 0; m_idx = 0; m_pend = 0;
    m_shadow = 0; m_disp = 0; m_sdp = 0; m_ddp = 0;
  endfunction

  function automatic void step();
    exp_t e;
    int unsigned upper;
    bit tick, frame, cap;
    e.cyc = edge_cnt + 1;
    e.seg = 0; e.dp = 0; e.dsel = 0;
    if (enable) begin
      upper  = m_disp >> (4 * m_idx);
      e.seg  = (m_idx > 0 && upper == 0) ? 7'h00 : font[upper & 15];
      e.dp   = m_ddp[m_idx];
      e.dsel = 4'(1 << m_idx);
    end
    tick  = enable && (m_presc == SD - 1);
    frame = tick && (m_idx == N - 1);
    cap   = value_valid && !m_pend;
    if (frame && m_pend) begin
      m_disp = m_shadow; m_ddp = m_sdp; m_pend = 0;
    end
    if (cap) begin
      m_shadow = value; m_sdp = dp_mask; m_pend = 1;
    end
    m_presc = (!enable || tick) ? 0 : m_presc + 1;
    if (tick) m_idx = (m_idx + 1) % N;
    e.ready = !m_pend;
    q.push_back(e);
  endfunction

  function automatic void cmp(string name,
      logic [6:0] s, logic d, logic [3:0] ds, logic r,
      logic [6:0] es, logic ed, logic [3:0] eds, logic er);
    checks++;
    if (s !== es || d !== ed || ds !== eds || r !== er) begin
      failures++;
      $display("FAIL %s t=%0t got seg=%h dp=%b dsel=%b rdy=%b want seg=%h dp=%b dsel=%b rdy=%b",
        name, $time, s, d, ds, r, es, ed, eds, er);
    end
  endfunction

  // Monitor: compares each edge that has an expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #3;
      if (q.size() > 0 && q[0].cyc == edge_cnt) begin
        e = q.pop_front();
        cmp("scan_hi", seg_h, dp_h, ds_h, ready_h,
            e.seg, e.dp, e.dsel, e.ready);
        cmp("scan_lo", seg_l, dp_l, ds_l, ready_l,
            e.seg ^ 7'h7F, ~e.dp, e.dsel ^ 4'hF, e.ready);
      end
    end
  end

  task automatic check_reset_out(string name);
    cmp({name, "_hi"}, seg_h, dp_h, ds_h, ready_h,
        7'h00, 1'b0, 4'h0, 1'b1);
    cmp({name, "_lo"}, seg_l, dp_l, ds_l, ready_l,
        7'h7F, 1'b1, 4'hF, 1'b1);
  endtask

  task automatic drive(bit en, bit vv,
      logic [15:0] v, logic [3:0] d);
    @(posedge clock);
    #1;
    enable = en; value_valid = vv;
    value = v; dp_mask = d;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'b0, $urandom, $urandom);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #5;
    reset_n = 1'b0;
    value_valid = 1'b0;
    q.delete();
    #1;
    check_reset_out("async_reset");
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check_reset_out("held_reset");
    reset_n = 1'b1;
    step();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int guard;
    int en_hold;
    bit en;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check_reset_out("reset_state");
    reset_n = 1'b1;
    enable  = 1'b1;
    step();

    // idle scan of an all-zero display
    idle(40);

    // mid-frame load, then a rejected second offer
    idle(5);
    drive(1'b1, 1'b1, 16'h12AF, 4'b0100);
    drive(1'b1, 1'b0, 16'h0, 4'h0);
    drive(1'b1, 1'b1, 16'h9999, 4'b1111);
    idle(40);

    // offer exactly on a frame-boundary edge
    guard = 0;
    while (!(m_presc == SD - 1 && m_idx == N - 1) && guard < 100) begin
      idle(1);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      failures++;
      $display("FAIL boundary_search guard=%0d want <100", guard);
    end
    drive(1'b1, 1'b1, 16'h0305, 4'b0001);
    idle(40);

    // enable low for 10 clocks mid-slot
    idle(6);
    for (int i = 0; i < 10; i++)
      drive(1'b0, 1'b0, 16'h0, 4'h0);
    idle(24);

    // reset in the middle of a frame with a value pending
    drive(1'b1, 1'b1, 16'hBEEF, 4'b1010);
    idle(3);
    do_reset();
    idle(20);

    // randomized phase
    en_hold = 0;
    en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      int unsigned v;
      if (en_hold > 0) begin
        en_hold--;
        if (en_hold == 0) en = 1'b1;
      end else if ($urandom_range(0, 49) == 0) begin
        en = 1'b0;
        en_hold = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        v = $urandom & (32'hFFFF >> (4 * $urandom_range(0, 4)));
        drive(en, en && ($urandom_range(0, 5) == 0),
              16'(v), 4'($urandom));
      end
    end
    idle(4);
    @(posedge clock);
    #4;

    checks++;
    if (q.size() > 1) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want <=1", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
